// File: rtl/axis_kernel_window_gen_if.sv
// -----------------------------------------------------------------------------
// axis_kernel_window_gen_if
//
// Bundle between a pixel-stream source and the sliding-window generator.
//
// Source side (driven by master):
//   data            pixel, channel 0 in the LSBs
//   data_valid      pixel accepted this cycle
//   start_of_frame  first pixel of a frame, qualified by data_valid
//   end_of_line     last pixel of a line, qualified by data_valid
//
// Window side (driven by slave, i.e. the generator):
//   window                [0][0] oldest (top-left), [K-1][K-1] newest pixel
//   window_valid          window lies fully inside the frame
//   window_start_of_frame first valid window of the frame
//   window_end_of_line    last valid window of a line
//   window_end_of_frame   last valid window of the frame
//   frame_error           sticky framing error
// -----------------------------------------------------------------------------
interface axis_kernel_window_gen_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int CHANNELS    = 1,
  parameter int KERNEL_SIZE = 3
);
  localparam int PW = DATA_WIDTH * CHANNELS;

  logic [PW-1:0] data;
  logic          data_valid;
  logic          start_of_frame;
  logic          end_of_line;

  logic [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1][PW-1:0] window;
  logic          window_valid;
  logic          window_start_of_frame;
  logic          window_end_of_line;
  logic          window_end_of_frame;
  logic          frame_error;

  modport master (
    output data, data_valid, start_of_frame, end_of_line,
    input  window, window_valid, window_start_of_frame,
           window_end_of_line, window_end_of_frame, frame_error
  );

  modport slave (
    input  data, data_valid, start_of_frame, end_of_line,
    output window, window_valid, window_start_of_frame,
           window_end_of_line, window_end_of_frame, frame_error
  );
endinterface

// File: rtl/axis_kernel_window_gen.sv
// -----------------------------------------------------------------------------
// axis_kernel_window_gen
//
// Sliding K x K window generator for a raster pixel stream. Tracks column/row
// position, keeps K-1 line delays and presents a registered window one cycle
// after each accepted pixel. The window is flagged valid only when it lies
// fully inside the frame (newest pixel at row >= K-1 and col >= K-1).
//
// Ports:
//   i_clk      clock
//   i_aresetn  asynchronous active-low reset
//   bus        axis_kernel_window_gen_if.slave (pixel in, window/flags out)
//
// Optional feature: define KWIN_FRAME_CHECK_EN to build the framing checker
// (end_of_line vs. column position, start_of_frame in mid-frame). Without it
// frame_error is tied to 0 and end_of_line is ignored.
// -----------------------------------------------------------------------------
module axis_kernel_window_gen #(
  parameter int DATA_WIDTH   = 8,
  parameter int CHANNELS     = 1,
  parameter int KERNEL_SIZE  = 3,
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480
) (
  input  logic                       i_clk,
  input  logic                       i_aresetn,
  axis_kernel_window_gen_if.slave    bus
);
  localparam int PW = DATA_WIDTH * CHANNELS;
  localparam int K  = KERNEL_SIZE;
  localparam int D  = IMAGE_WIDTH - KERNEL_SIZE;   // line-buffer depth per row
  localparam int CW = $clog2(IMAGE_WIDTH);
  localparam int RW = $clog2(IMAGE_HEIGHT);

  localparam logic [CW-1:0] LAST_COL = CW'(IMAGE_WIDTH - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMAGE_HEIGHT - 1);
  localparam logic [CW-1:0] MIN_COL  = CW'(K - 1);
  localparam logic [RW-1:0] MIN_ROW  = RW'(K - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t        state, state_next;
  logic [CW-1:0] col, col_next, pix_col;
  logic [RW-1:0] row, row_next, pix_row;
  logic          shift, at_last_col, at_frame_end;

  logic [0:K-1][0:K-1][PW-1:0] win;
  logic [0:K-2][0:D-1][PW-1:0] lb;
  logic valid_q, sof_q, eol_q, eof_q;

  // Position of the pixel being accepted: start_of_frame forces (0,0) in
  // either state, which is how a mid-frame resync re-aligns the counters.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    pix_col    = col;
    pix_row    = row;
    shift      = 1'b0;
    col_next   = col;
    row_next   = row;

    if (bus.data_valid && bus.start_of_frame) begin
      pix_col = '0;
      pix_row = '0;
      shift   = 1'b1;
    end else if (bus.data_valid && state == ACTIVE) begin
      shift   = 1'b1;
    end

    at_last_col  = (pix_col == LAST_COL);
    at_frame_end = at_last_col && (pix_row == LAST_ROW);

    if (shift) begin
      state_next = at_frame_end ? IDLE : ACTIVE;
      col_next   = at_last_col ? '0 : pix_col + 1'b1;
      if (at_frame_end)     row_next = '0;
      else if (at_last_col) row_next = pix_row + 1'b1;
      else                  row_next = pix_row;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state <= IDLE;
      col   <= '0;
      row   <= '0;
    end else begin
      state <= state_next;
      col   <= col_next;
      row   <= row_next;
    end
  end

  // Window and line delays. Pixels leaving the left of window row i+1 enter
  // line buffer i, whose output feeds the right of window row i; the total
  // delay K + D equals one line, so rows stay vertically aligned.
  // NOTE: the line buffers are a reset shift register (not a RAM) because
  // they must read back as zero after reset.
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      win     <= '0;
      lb      <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
      if (shift) begin
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K - 1; j++)
            win[i][j] <= win[i][j+1];
        win[K-1][K-1] <= bus.data;
        for (int i = 0; i < K - 1; i++) begin
          win[i][K-1] <= lb[i][0];
          for (int d = 0; d < D - 1; d++)
            lb[i][d] <= lb[i][d+1];
          lb[i][D-1] <= win[i+1][0];
        end
        if (pix_row >= MIN_ROW && pix_col >= MIN_COL) begin
          valid_q <= 1'b1;
          sof_q   <= (pix_row == MIN_ROW) && (pix_col == MIN_COL);
          eol_q   <= at_last_col;
          eof_q   <= at_frame_end;
        end
      end
    end
  end

  assign bus.window                = win;
  assign bus.window_valid          = valid_q;
  assign bus.window_start_of_frame = sof_q;
  assign bus.window_end_of_line    = eol_q;
  assign bus.window_end_of_frame   = eof_q;

`ifdef KWIN_FRAME_CHECK_EN
  logic err_q, err_set, err_clr;

  // A start_of_frame while ACTIVE is always a resync away from a frame
  // boundary, since a completed frame returns the FSM to IDLE.
  assign err_set = shift && ((bus.end_of_line != at_last_col) ||
                   (state == ACTIVE && bus.start_of_frame &&
                    !(row == '0 && col == '0)));
  assign err_clr = bus.data_valid && bus.start_of_frame && state == IDLE;

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn)   err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
    else if (err_clr) err_q <= 1'b0;
  end

  assign bus.frame_error = err_q;
`else
  logic unused_eol;
  assign unused_eol      = bus.end_of_line;
  assign bus.frame_error = 1'b0;
`endif

endmodule

// File: tb/tb_axis_kernel_window_gen.sv
// -----------------------------------------------------------------------------
// tb_axis_kernel_window_gen
//
// Randomised bench for axis_kernel_window_gen with K=3, W=8, H=6, one 8-bit
// channel. The reference model indexes a stored image by each pixel's flat
// position in the frame; expected frame_error follows KWIN_FRAME_CHECK_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axis_kernel_window_gen;
  localparam int DW = 8;
  localparam int CH = 1;
  localparam int K  = 3;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int PW = DW * CH;

  typedef logic [0:K-1][0:K-1][PW-1:0] win_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axis_kernel_window_gen_if #(.DATA_WIDTH(DW), .CHANNELS(CH), .KERNEL_SIZE(K)) bus ();

  axis_kernel_window_gen #(
    .DATA_WIDTH(DW), .CHANNELS(CH), .KERNEL_SIZE(K),
    .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)
  ) dut (
    .i_clk(clk),
    .i_aresetn(rst_n),
    .bus(bus)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // reference model state
  bit            m_active;
  int            m_n;
  bit            m_err;
  logic [PW-1:0] img [0:H-1][0:W-1];
  win_t          exp_win;
  bit            exp_known;

  // per-frame statistics gathered from checked cycles
  int   win_cnt;
  int   eol_newest[$];
  int   eof_newest;
  win_t first_win;
  bit   first_seen;

`ifdef KWIN_FRAME_CHECK_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  task automatic model_reset();
    m_active  = 1'b0;
    m_n       = 0;
    m_err     = 1'b0;
    exp_win   = '0;
    exp_known = 1'b1;
  endtask

  task automatic clear_stats();
    win_cnt    = 0;
    eol_newest = {};
    eof_newest = -1;
    first_seen = 1'b0;
  endtask

  // Drive one cycle, advance the model, and score every output.
  task automatic step(input bit v, input logic [PW-1:0] d, input bit sof, input bit eol);
    bit e_valid = 1'b0, e_sof = 1'b0, e_eol = 1'b0, e_eof = 1'b0;
    int r, c;
    if (v) begin
      if (sof) begin
        if (ERR_ON) m_err = m_active ? 1'b1 : 1'b0;
        m_active = 1'b1;
        m_n      = 0;
      end
      if (m_active) begin
        r = m_n / W;
        c = m_n % W;
        img[r][c] = d;
        if (ERR_ON && (eol != (c == W - 1))) m_err = 1'b1;
        if (r >= K - 1 && c >= K - 1) begin
          e_valid = 1'b1;
          e_sof   = (r == K - 1) && (c == K - 1);
          e_eol   = (c == W - 1);
          e_eof   = (r == H - 1) && (c == W - 1);
          for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
              exp_win[i][j] = img[r-K+1+i][c-K+1+j];
          exp_known = 1'b1;
        end else begin
          exp_known = 1'b0;
        end
        m_n++;
        if (m_n == W * H) m_active = 1'b0;
      end
    end

    bus.data           = d;
    bus.data_valid     = v;
    bus.start_of_frame = sof;
    bus.end_of_line    = eol;
    @(posedge clk);
    #1;

    tests_run++;
    if (bus.window_valid !== e_valid) begin
      tests_failed++;
      $display("FAIL window_valid: got %b want %b (n=%0d)", bus.window_valid, e_valid, m_n);
    end
    tests_run++;
    if ({bus.window_start_of_frame, bus.window_end_of_line, bus.window_end_of_frame} !==
        {e_sof, e_eol, e_eof}) begin
      tests_failed++;
      $display("FAIL flags sof/eol/eof: got %b%b%b want %b%b%b", bus.window_start_of_frame,
               bus.window_end_of_line, bus.window_end_of_frame, e_sof, e_eol, e_eof);
    end
    tests_run++;
    if (bus.frame_error !== m_err) begin
      tests_failed++;
      $display("FAIL frame_error: got %b want %b", bus.frame_error, m_err);
    end
    if (exp_known) begin
      tests_run++;
      if (bus.window !== exp_win) begin
        tests_failed++;
        $display("FAIL window: got %h want %h", bus.window, exp_win);
      end
    end

    if (e_valid && bus.window_valid) begin
      win_cnt++;
      if (!first_seen) begin
        first_win  = bus.window;
        first_seen = 1'b1;
      end
      if (bus.window_end_of_line)  eol_newest.push_back(int'(bus.window[K-1][K-1]));
      if (bus.window_end_of_frame) eof_newest = int'(bus.window[K-1][K-1]);
    end
  endtask

  task automatic idle_cycle();
    logic [PW-1:0] junk;
    junk = PW'($urandom);
    step(1'b0, junk, 1'($urandom), 1'($urandom));
  endtask

  // Send pixels 0..count-1 of a frame; bad_eol marks one extra end_of_line.
  task automatic send_pixels(input int count, input int gap_pct, input bit rand_data,
                             input int bad_eol);
    logic [PW-1:0] d;
    for (int n = 0; n < count; n++) begin
      if (int'($urandom_range(99)) < gap_pct)
        repeat ($urandom_range(1, 3)) idle_cycle();
      d = rand_data ? PW'($urandom) : PW'(n);
      step(1'b1, d, n == 0, (n % W == W - 1) || (n == bad_eol));
    end
  endtask

  task automatic check_frame_stats(input string tag);
    int exp_eol [4] = '{23, 31, 39, 47};
    tests_run++;
    if (win_cnt !== 24) begin
      tests_failed++;
      $display("FAIL %s window count: got %0d want 24", tag, win_cnt);
    end
    tests_run++;
    if (eol_newest.size() != 4) begin
      tests_failed++;
      $display("FAIL %s eol count: got %0d want 4", tag, eol_newest.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (eol_newest[i] != exp_eol[i]) begin
          tests_failed++;
          $display("FAIL %s eol newest[%0d]: got %0d want %0d", tag, i, eol_newest[i], exp_eol[i]);
        end
      end
    end
    tests_run++;
    if (eof_newest != 47) begin
      tests_failed++;
      $display("FAIL %s eof newest: got %0d want 47", tag, eof_newest);
    end
    tests_run++;
    begin
      win_t fw;
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K; j++)
          fw[i][j] = PW'(i * W + j);
      if (!first_seen || first_win !== fw) begin
        tests_failed++;
        $display("FAIL %s first window: got %h want %h", tag, first_win, fw);
      end
    end
  endtask

  task automatic test_reset();
    bus.data = '0; bus.data_valid = 1'b0;
    bus.start_of_frame = 1'b0; bus.end_of_line = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({bus.window_valid, bus.window_start_of_frame, bus.window_end_of_line,
         bus.window_end_of_frame, bus.frame_error} !== 5'b0 || bus.window !== '0) begin
      tests_failed++;
      $display("FAIL reset outputs: got flags %b window %h want all 0",
               {bus.window_valid, bus.window_start_of_frame, bus.window_end_of_line,
                bus.window_end_of_frame, bus.frame_error}, bus.window);
    end
    rst_n = 1'b1;
    idle_cycle();
  endtask

  task automatic test_continuous();
    clear_stats();
    send_pixels(W * H, 0, 1'b0, -1);
    check_frame_stats("continuous");
    idle_cycle();
  endtask

  task automatic test_gaps();
    clear_stats();
    send_pixels(W * H, 40, 1'b0, -1);
    check_frame_stats("gaps");
    clear_stats();
    send_pixels(W * H, 30, 1'b1, -1);
    tests_run++;
    if (win_cnt !== 24) begin
      tests_failed++;
      $display("FAIL random-data window count: got %0d want 24", win_cnt);
    end
    idle_cycle();
  endtask

  task automatic test_no_sof();
    for (int i = 0; i < 5; i++) step(1'b1, PW'(100 + i), 1'b0, 1'b0);
    clear_stats();
    send_pixels(W * H, 0, 1'b0, -1);
    check_frame_stats("no_sof");
    idle_cycle();
  endtask

  task automatic test_back_to_back_resync();
    send_pixels(3 * W + 4, 0, 1'b1, -1);   // up to (3,3); next pixel is (3,4)
    clear_stats();
    step(1'b1, PW'(0), 1'b1, 1'b0);          // SOF lands at (3,4)
    tests_run++;
    if (bus.frame_error !== ERR_ON) begin
      tests_failed++;
      $display("FAIL resync frame_error: got %b want %b", bus.frame_error, ERR_ON);
    end
    for (int n = 1; n < W * H; n++) step(1'b1, PW'(n), 1'b0, n % W == W - 1);
    check_frame_stats("resync");
    idle_cycle();
    step(1'b1, PW'(0), 1'b1, 1'b0);          // clean SOF from IDLE
    tests_run++;
    if (bus.frame_error !== 1'b0) begin
      tests_failed++;
      $display("FAIL error clear on IDLE SOF: got %b want 0", bus.frame_error);
    end
    for (int n = 1; n < W * H; n++) step(1'b1, PW'(n), 1'b0, n % W == W - 1);
    idle_cycle();
  endtask

  task automatic test_eol_error();
    clear_stats();
    send_pixels(W + 6, 0, 1'b0, W + 5);      // extra end_of_line on (1,5)
    tests_run++;
    if (bus.frame_error !== ERR_ON) begin
      tests_failed++;
      $display("FAIL eol frame_error: got %b want %b", bus.frame_error, ERR_ON);
    end
    for (int n = W + 6; n < W * H; n++) step(1'b1, PW'(n), 1'b0, n % W == W - 1);
    check_frame_stats("eol_error");
    idle_cycle();
  endtask

  task automatic test_mid_reset();
    send_pixels(30, 0, 1'b0, -1);
    bus.data = PW'(30); bus.data_valid = 1'b1;
    bus.start_of_frame = 1'b0; bus.end_of_line = 1'b0;
    rst_n = 1'b0;
    model_reset();
    for (int cyc = 0; cyc < 4; cyc++) begin
      #1;
      tests_run++;
      if ({bus.window_valid, bus.window_start_of_frame, bus.window_end_of_line,
           bus.window_end_of_frame, bus.frame_error} !== 5'b0 || bus.window !== '0) begin
        tests_failed++;
        $display("FAIL outputs during reset cycle %0d: flags %b window %h want all 0", cyc,
                 {bus.window_valid, bus.window_start_of_frame, bus.window_end_of_line,
                  bus.window_end_of_frame, bus.frame_error}, bus.window);
      end
      @(posedge clk);
    end
    #1;
    rst_n = 1'b1;
    idle_cycle();
    clear_stats();
    send_pixels(W * H, 0, 1'b0, -1);
    check_frame_stats("after_reset");
  endtask

  initial begin
    model_reset();
    test_reset();
    test_continuous();
    test_gaps();
    test_no_sof();
    test_back_to_back_resync();
    test_eol_error();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/axis_kernel_window_gen.md
# axis_kernel_window_gen

Parametrised, multi-channel sliding-window generator for the streaming image pipeline. Accepts an AXI-Stream-style pixel stream, tracks column/row position, buffers KERNEL_SIZE-1 lines and presents a KERNEL_SIZE x KERNEL_SIZE window, flagged valid only when the window lies fully inside the frame. It sits between the AXIS input stage and the kernel operators (median, convolution), and supplies aligned start-of-frame, end-of-line and end-of-frame markers.

## Interface
- DATA_WIDTH, 8, bits per channel sample
- CHANNELS, 1, samples per pixel; pixel width PW = CHANNELS*DATA_WIDTH
- KERNEL_SIZE, 3, window side K; odd, >= 3
- IMAGE_WIDTH, 640, pixels per line W; W > K
- IMAGE_HEIGHT, 480, lines per frame H; H >= K

- i_clk  in  1  clock
- i_aresetn  in  1  asynchronous active-low reset
- i_data  in  PW  pixel, channel 0 in LSBs
- i_data_valid  in  1  pixel accepted this cycle
- i_start_of_frame  in  1  first pixel of frame; qualified by i_data_valid
- i_end_of_line  in  1  last pixel of line; qualified by i_data_valid
- o_window  out  PW x [0:K-1][0:K-1]  window; [0][0] oldest (top-left), [K-1][K-1] newest pixel
- o_window_valid  out  1  window fully inside frame
- o_start_of_frame  out  1  first valid window of frame
- o_end_of_line  out  1  last valid window of a line
- o_end_of_frame  out  1  last valid window of frame
- o_frame_error  out  1  sticky framing error (see Configuration)

## Operation
- States: IDLE, ACTIVE. Reset -> IDLE.
- IDLE: accepted pixels without i_start_of_frame are dropped (no shift, no count). Accepted pixel with SOF: col=0, row=0, shift it in, -> ACTIVE.
- ACTIVE: each accepted pixel shifts window row K-1 left; the pixel exiting each window row enters the line buffer feeding the row above (depth W-K per line, K-1 lines). col increments, wraps W-1->0 with row+1.
- Accepted pixel at (row H-1, col W-1): -> IDLE after shift.
- SOF accepted in ACTIVE: resync; counters to (0,0) for that pixel, buffers not cleared, stay ACTIVE.
- Window valid for newest pixel (r,c) iff r >= K-1 and c >= K-1; windows straddling line wrap suppressed.
- o_start_of_frame: valid window at (K-1,K-1). o_end_of_line: valid window at c=W-1. o_end_of_frame: (H-1,W-1).
- No i_data_valid: no shift, no count, all flags 0 next cycle; o_window holds.

## Timing
- Reset: o_window all 0, line buffers 0, all flags 0, counters 0, IDLE; effective immediately, mid-frame included.
- Latency: 1 cycle from acceptance of pixel (r,c) to registered window with newest tap (r,c).
- Throughput: one pixel per cycle, arbitrary gaps.
- Flags are single-cycle pulses coincident with o_window_valid.

## Configuration
- KWIN_FRAME_CHECK_EN defined: o_frame_error set 1 cycle after accepted pixel where i_end_of_line disagrees with col==W-1, or SOF arrives in ACTIVE not at (0,0) of a new frame; cleared by reset or by accepted SOF in IDLE. Datapath unaffected.
- Undefined: check logic absent, o_frame_error tied 0; i_end_of_line ignored.

## Test plan
Common: K=3, W=8, H=6, CHANNELS=1, pixel value = row*8+col, macro defined unless noted.
- Reset, continuous frame -> first o_window_valid 1 cycle after pixel 18, window rows {0,1,2},{8,9,10},{16,17,18}, o_start_of_frame=1; exactly 24 valid windows; last window newest 47 with o_end_of_frame=1; o_end_of_line on 23,31,39,47.
- Same frame with random valid gaps -> identical 24 windows in order; flags 0 during gaps.
- Five pixels without SOF before frame -> ignored; output identical to first scenario.
- SOF re-asserted at (3,4) followed by full frame -> o_frame_error=1 next cycle; 24 valid windows of new frame; next clean frame after IDLE SOF clears error.
- i_end_of_line on (1,5) -> o_frame_error=1; with macro undefined -> stays 0, windows unchanged.
- i_aresetn low at pixel 30 then full frame -> all outputs 0 while low; subsequent frame matches first scenario.
